// File: rtl/cam_wr_pkg.sv
// Shared types and helpers for the multi-channel camera write arbiter.
package cam_wr_pkg;

    localparam int BURST_LEN_DEF = 512;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        REQ,
        BUSY
    } state_t;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_wr_arbiter_if.sv
// Burst-write handshake between the camera write arbiter and the SDRAM controller.
interface cam_wr_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10,
    parameter int CH_W   = 1
);
    logic              wr_req;
    logic              wr_ack;
    logic              wr_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic [CH_W-1:0]   wr_ch;

    modport master (
        output wr_req, wr_addr, wr_len, wr_ch,
        input  wr_ack, wr_done
    );

    modport slave (
        input  wr_req, wr_addr, wr_len, wr_ch,
        output wr_ack, wr_done
    );
endinterface

// File: rtl/cam_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int CH_NUM = 2,
    parameter int CH_W   = 1
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_NUM-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);
    logic [CH_W-1:0] idx;

    // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            idx = CH_W'((32'(last_grant) + 32'(k)) % 32'(CH_NUM));
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cam_wr_arbiter.sv
// Merges N buffered camera streams onto one SDRAM burst-write port with
// round-robin arbitration and per-channel ping-pong frame banks.
module cam_wr_arbiter
    import cam_wr_pkg::*;
#(
    parameter int CH_NUM    = 2,
    parameter int ADDR_W    = 24,
    parameter int LEN_W     = 10,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [CH_NUM*LEN_W-1:0]  ch_rdusedw,
    input  logic [CH_NUM-1:0]        ch_frame_start,
    input  logic [CH_NUM*ADDR_W-1:0] ch_base_addr,
    input  logic [ADDR_W-1:0]        frame_words,
    cam_wr_arbiter_if.master         wr_bus,
    output logic [CH_NUM-1:0]        rd_bank_sel,
    output logic [CH_NUM-1:0]        frame_valid,
    output logic [CH_NUM-1:0]        frame_done
);
    state_t            state_q, state_d;
    logic              wr_req_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [LEN_W-1:0]  wr_len_q;
    logic [CH_W-1:0]   wr_ch_q;
    logic [CH_W-1:0]   last_grant_q;

    logic [CH_NUM-1:0] eligible;
    logic [CH_NUM-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_valid;
    logic [ADDR_W-1:0] ch_addr [CH_NUM];
    logic [LEN_W-1:0]  ch_need [CH_NUM];

    logic burst_live;
    logic burst_done;

    assign burst_live = (state_q == REQ) || (state_q == BUSY);
    assign burst_done = (state_q == BUSY) && wr_bus.wr_done;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [ADDR_W-1:0] offset_q;
        logic [ADDR_W-1:0] offset_next;
        logic [ADDR_W-1:0] remaining;
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  rdusedw;
        logic              wr_bank_q;
        logic              bank_sel_q;
        logic              valid_q;
        logic              done_q;
        logic              restart_q;
        logic              in_flight;
        logic              done_here;

        assign base        = ch_base_addr[i*ADDR_W +: ADDR_W];
        assign rdusedw     = ch_rdusedw[i*LEN_W +: LEN_W];
        assign remaining   = frame_words - offset_q;
        assign ch_need[i]  = LEN_W'(min_u32(32'(BURST_LEN), 32'(remaining)));
        assign eligible[i] = enable && (offset_q < frame_words) && (rdusedw >= ch_need[i]);
        assign ch_addr[i]  = base + (wr_bank_q ? frame_words : '0) + offset_q;
        assign offset_next = offset_q + ADDR_W'(wr_len_q);
        assign done_here   = burst_done && (wr_ch_q == CH_W'(i));
        // A grant being registered in ARB already owns the old offset, so restarts defer too.
        assign in_flight   = (burst_live && (wr_ch_q == CH_W'(i))) || ((state_q == ARB) && grant[i]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                offset_q   <= '0;
                wr_bank_q  <= 1'b0;
                bank_sel_q <= 1'b1;
                valid_q    <= 1'b0;
                done_q     <= 1'b0;
                restart_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (done_here) begin
                    if (offset_next == frame_words) begin
                        done_q     <= 1'b1;
                        valid_q    <= 1'b1;
                        bank_sel_q <= wr_bank_q;
                        wr_bank_q  <= ~wr_bank_q;
                    end
                    if (restart_q || ch_frame_start[i]) begin
                        offset_q  <= '0;
                        restart_q <= 1'b0;
                    end else begin
                        offset_q <= offset_next;
                    end
                end else if (ch_frame_start[i]) begin
                    if (in_flight) restart_q <= 1'b1;
                    else           offset_q  <= '0;
                end
            end
        end

        assign rd_bank_sel[i] = bank_sel_q;
        assign frame_valid[i] = valid_q;
        assign frame_done[i]  = done_q;
    end

    rr_arbiter #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_rr (
        .req         (eligible),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = ARB;
            ARB:     state_d = grant_valid ? REQ : IDLE;
            REQ:     if (wr_bus.wr_ack) state_d = BUSY;
            BUSY:    if (wr_bus.wr_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst descriptor is captured once in ARB and held stable through REQ/BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            wr_ch_q      <= '0;
            last_grant_q <= CH_W'(CH_NUM - 1);
        end else if ((state_q == ARB) && grant_valid) begin
            wr_req_q     <= 1'b1;
            wr_addr_q    <= ch_addr[grant_idx];
            wr_len_q     <= ch_need[grant_idx];
            wr_ch_q      <= grant_idx;
            last_grant_q <= grant_idx;
        end else if ((state_q == REQ) && wr_bus.wr_ack) begin
            wr_req_q <= 1'b0;
        end
    end

    assign wr_bus.wr_req  = wr_req_q;
    assign wr_bus.wr_addr = wr_addr_q;
    assign wr_bus.wr_len  = wr_len_q;
    assign wr_bus.wr_ch   = wr_ch_q;
endmodule

// File: tb/tb_cam_wr_arbiter.sv
// Bench for cam_wr_arbiter: two channels, 1280-word frames, controller modelled by ack/done pulses.
module tb_cam_wr_arbiter;
    localparam int CH_NUM = 2;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;
    localparam int CH_W   = 1;
    localparam logic [ADDR_W-1:0] BASE1 = 24'h100000;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     enable = 1'b0;
    logic [CH_NUM*LEN_W-1:0]  ch_rdusedw = '0;
    logic [CH_NUM-1:0]        ch_frame_start = '0;
    logic [CH_NUM*ADDR_W-1:0] ch_base_addr = '0;
    logic [ADDR_W-1:0]        frame_words = '0;
    logic [CH_NUM-1:0]        rd_bank_sel;
    logic [CH_NUM-1:0]        frame_valid;
    logic [CH_NUM-1:0]        frame_done;

    cam_wr_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CH_W(CH_W)) bus ();

    cam_wr_arbiter #(
        .CH_NUM (CH_NUM),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .ch_rdusedw     (ch_rdusedw),
        .ch_frame_start (ch_frame_start),
        .ch_base_addr   (ch_base_addr),
        .frame_words    (frame_words),
        .wr_bus         (bus),
        .rd_bank_sel    (rd_bank_sel),
        .frame_valid    (frame_valid),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ch;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [1:0]        done_mask;
        logic [1:0]        rdsel;
        logic [1:0]        valid;
    } exp_t;

    typedef struct {
        logic [1:0]       busy_fs;
        logic [1:0]       post_fs;
        logic [LEN_W-1:0] rd_after;
        exp_t             exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [1:0] busy_fs, input logic [1:0] post_fs,
                                input logic [LEN_W-1:0] rd_after, input logic ch,
                                input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                input logic [1:0] dm, input logic [1:0] rs, input logic [1:0] vl);
        vec_t v;
        v.busy_fs = busy_fs;
        v.post_fs = post_fs;
        v.rd_after = rd_after;
        v.exp.ch = ch;
        v.exp.addr = addr;
        v.exp.len = len;
        v.exp.done_mask = dm;
        v.exp.rdsel = rs;
        v.exp.valid = vl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_req"}, 32'(bus.wr_req), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_len"}, 32'(bus.wr_len), 32'd0);
        check({tag, "_wr_ch"}, 32'(bus.wr_ch), 32'd0);
        check({tag, "_rd_bank_sel"}, 32'(rd_bank_sel), 32'h3);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.wr_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_req_seen", 32'(bus.wr_req), 32'd1);
    endtask

    task automatic take_req(output exp_t e);
        wait_req();
        e = sb.pop_front();
        check("wr_ch", 32'(bus.wr_ch), 32'(e.ch));
        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check("wr_len", 32'(bus.wr_len), 32'(e.len));
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        check("wr_req_drop", 32'(bus.wr_req), 32'd0);
    endtask

    task automatic serve(input logic [1:0] busy_fs, input logic [1:0] post_fs,
                         input logic [LEN_W-1:0] rd_after);
        exp_t e;
        take_req(e);
        if (busy_fs != 2'b00) begin
            ch_frame_start = busy_fs;
            @(negedge clk);
            ch_frame_start = 2'b00;
        end
        @(negedge clk);
        check("frame_done_mid", 32'(frame_done), 32'd0);
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        ch_frame_start = post_fs;
        ch_rdusedw = {rd_after, rd_after};
        check("frame_done", 32'(frame_done), 32'(e.done_mask));
        check("rd_bank_sel", 32'(rd_bank_sel), 32'(e.rdsel));
        check("frame_valid", 32'(frame_valid), 32'(e.valid));
        @(negedge clk);
        ch_frame_start = 2'b00;
        check("frame_done_clear", 32'(frame_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic seen_req;
        logic [1:0] seen_done;

        //           busy   post   rd     ch    addr          len     dm     rs     vl
        vecs[0]  = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000000, 10'd512, 2'b00, 2'b11, 2'b00);
        vecs[1]  = mk(2'b00, 2'b00, 10'd600, 1'b1, 24'h100000, 10'd512, 2'b00, 2'b11, 2'b00);
        vecs[2]  = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000200, 10'd512, 2'b00, 2'b11, 2'b00);
        vecs[3]  = mk(2'b00, 2'b00, 10'd600, 1'b1, 24'h100200, 10'd512, 2'b00, 2'b11, 2'b00);
        vecs[4]  = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000400, 10'd256, 2'b01, 2'b10, 2'b01);
        vecs[5]  = mk(2'b00, 2'b11, 10'd600, 1'b1, 24'h100400, 10'd256, 2'b10, 2'b00, 2'b11);
        vecs[6]  = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000500, 10'd512, 2'b00, 2'b00, 2'b11);
        vecs[7]  = mk(2'b00, 2'b00, 10'd600, 1'b1, 24'h100500, 10'd512, 2'b00, 2'b00, 2'b11);
        vecs[8]  = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000700, 10'd512, 2'b00, 2'b00, 2'b11);
        vecs[9]  = mk(2'b00, 2'b01, 10'd600, 1'b1, 24'h100700, 10'd512, 2'b00, 2'b00, 2'b11);
        vecs[10] = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000500, 10'd512, 2'b00, 2'b00, 2'b11);
        vecs[11] = mk(2'b00, 2'b10, 10'd600, 1'b1, 24'h100900, 10'd256, 2'b10, 2'b10, 2'b11);
        vecs[12] = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000700, 10'd512, 2'b00, 2'b10, 2'b11);
        vecs[13] = mk(2'b10, 2'b00, 10'd600, 1'b1, 24'h100000, 10'd512, 2'b00, 2'b10, 2'b11);
        vecs[14] = mk(2'b00, 2'b00, 10'd600, 1'b0, 24'h000900, 10'd256, 2'b01, 2'b11, 2'b11);
        vecs[15] = mk(2'b00, 2'b11, 10'd511, 1'b1, 24'h100000, 10'd512, 2'b00, 2'b11, 2'b11);

        bus.wr_ack = 1'b0;
        bus.wr_done = 1'b0;
        frame_words = 24'd1280;
        ch_base_addr = {BASE1, 24'h000000};

        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        enable = 1'b1;
        ch_rdusedw = {10'd600, 10'd600};

        // Alternating bursts, partial tail bursts, bank swaps and frame restarts.
        for (int i = 0; i < 16; i++) begin
            sb.push_back(vecs[i].exp);
            serve(vecs[i].busy_fs, vecs[i].post_fs, vecs[i].rd_after);
        end

        // One word short of a full burst must not request; reaching it requests two cycles later.
        seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_req |= bus.wr_req;
        end
        check("no_req_511", 32'(seen_req), 32'd0);
        ch_rdusedw = {10'd511, 10'd512};
        e = '{ch: 1'b0, addr: 24'h000000, len: 10'd512, done_mask: 2'b00, rdsel: 2'b11, valid: 2'b11};
        sb.push_back(e);
        @(negedge clk);
        check("req_latency_1", 32'(bus.wr_req), 32'd0);
        @(negedge clk);
        check("req_latency_2", 32'(bus.wr_req), 32'd1);
        serve(2'b00, 2'b00, 10'd0);

        // Reset while a burst is in BUSY, then stray ack/done after release.
        ch_rdusedw = {10'd0, 10'd600};
        e = '{ch: 1'b0, addr: 24'h000200, len: 10'd512, done_mask: 2'b00, rdsel: 2'b11, valid: 2'b11};
        sb.push_back(e);
        take_req(e);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("busy_reset");
        ch_rdusedw = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        seen_req = 1'b0;
        seen_done = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen_req |= bus.wr_req;
            seen_done |= frame_done;
        end
        check("stray_req", 32'(seen_req), 32'd0);
        check("stray_done", 32'(seen_done), 32'd0);
        ch_rdusedw = {10'd0, 10'd600};
        e = '{ch: 1'b0, addr: 24'h000000, len: 10'd512, done_mask: 2'b00, rdsel: 2'b11, valid: 2'b00};
        sb.push_back(e);
        serve(2'b00, 2'b00, 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
